param_sync_fifo: RTL
====================

Name: param_sync_fifo

Overview:
- Parametrised single-clock FIFO; the next-generation buffer for switch ingress/egress queues.
- Generalises the fixed 8-bit on-clock FIFO in data width, depth and threshold flags.
- Adds occupancy count, almost-full/almost-empty, sticky overflow/underflow error flags and a synchronous flush.
- Sits between a port MAC-side writer and the EDF scheduler read side. Both sides run on the same clock.

Parameters:
- WIDTH, 8: data word width in bits.
- DEPTH, 16: number of entries. Must be a power of 2 and at least 2.
- AF_LEVEL, 14: almost_full asserts when count >= AF_LEVEL. Range 1..DEPTH.
- AE_LEVEL, 2: almost_empty asserts when count <= AE_LEVEL. Range 0..DEPTH-1.

Ports:
- CLK  in  1  clock; all logic on its rising edge.
- RST  in  1  synchronous, active-high reset.
- flush  in  1  synchronous clear of FIFO contents and error flags.
- write  in  1  write request.
- iData  in  WIDTH  write data.
- read  in  1  read request.
- oData  out  WIDTH  read data.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count >= AF_LEVEL.
- almost_empty  out  1  count <= AE_LEVEL.
- count  out  clog2(DEPTH)+1  current occupancy.
- overflow  out  1  sticky: a write was rejected.
- underflow  out  1  sticky: a read was rejected.

Behaviour:
- Reset is synchronous and active-high; the clock port is CLK and the reset port is RST.
- AW = clog2(DEPTH). Write and read pointers are AW+1 bits wide. Memory is indexed by pointer[AW-1:0]. The pointer MSB distinguishes full from empty.
- count = wr_ptr - rd_ptr, computed modulo 2^(AW+1). full, empty, almost_full and almost_empty are decoded from count.
- Flags and count are functions of registered state only. They reflect an accepted operation on the cycle after its clock edge.
- wr_acc = write & ~full. On wr_acc: mem[wr_idx] <= iData, wr_ptr increments.
- rd_acc = read & ~empty. On rd_acc: rd_ptr increments.
- No bypass. A write at full is rejected even if a read is accepted in the same cycle. A read at empty is rejected even if a write is accepted in the same cycle.
- Simultaneous wr_acc and rd_acc: count unchanged, both pointers advance.
- Wrap-around: pointers roll over naturally at 2^(AW+1); there is no special case.
- overflow is set on (write & full) and stays set until RST or flush. underflow is set on (read & empty) and stays set until RST or flush.
- Priority: RST > flush > write/read.
- flush zeroes both pointers and clears overflow and underflow. Any write or read in the same cycle is ignored and does not set an error flag. Memory contents are not cleared. In standard mode oData holds its value across a flush.
- Reset values: count=0, empty=1, full=0, almost_full=0, almost_empty=1, overflow=0, underflow=0, oData=0.
- Reset mid-operation: all pending data is discarded. The state one cycle after RST asserts equals the reset values.
- Standard mode (macro undefined):
  - oData is registered; on rd_acc, oData <= mem[rd_idx].
  - Read latency is 1 cycle: data is valid on the cycle after the read edge.
  - oData holds its last value when there is no rd_acc.

Optional Feature:
- Macro: PARAM_SYNC_FIFO_FWFT_EN.
- Defined (first-word fall-through):
  - oData = empty ? 0 : mem[rd_idx], combinational from registered state.
  - The head word is visible on the cycle after the write edge that made the FIFO non-empty, with no read needed.
  - read acts as a pop/acknowledge.
  - Flags, count and error behaviour are identical to standard mode.
- Undefined: standard registered-read mode as described in Behaviour.

Test Plan:
- Assert RST 2 cycles, then release -> count=0, empty=1, almost_empty=1, full=0, oData=0, overflow=underflow=0.
- Write 16 words 1..16 with no reads -> almost_full rises on the edge after the 14th write, full=1 and count=16 after the 16th; a 17th write -> overflow=1, count stays 16, the stored value 17 never appears.
- From full, read 16 cycles -> standard mode: oData = 1..16 in order, each one cycle after its read edge; then empty=1; an extra read -> underflow=1, oData holds 16.
- Continuous simultaneous write+read for 40 cycles starting at count=3 -> count stays 3, the data sequence is preserved across pointer wrap at 16 and 32, no error flags.
- Assert flush together with write at count=9 with overflow=1 -> next cycle count=0, empty=1, overflow=0, and the write in the flush cycle is not stored.
- With PARAM_SYNC_FIFO_FWFT_EN defined, write 0xA5 into an empty FIFO -> oData=0xA5 on the next cycle with no read; read once -> empty=1, oData=0.

Source files
------------

// File: rtl/param_sync_fifo.sv
// param_sync_fifo: parametrised single-clock FIFO with occupancy count, threshold flags and sticky errors.
// Define PARAM_SYNC_FIFO_FWFT_EN for first-word fall-through output; the default is a registered read.
module param_sync_fifo #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = 14,
    parameter int AE_LEVEL = 2
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       flush,
    input  logic                       write,
    input  logic [WIDTH-1:0]           iData,
    input  logic                       read,
    output logic [WIDTH-1:0]           oData,
    output logic                       full,
    output logic                       empty,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic                       underflow
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [AW:0] AF_C    = (AW+1)'(AF_LEVEL);
    localparam logic [AW:0] AE_C    = (AW+1)'(AE_LEVEL);
    localparam logic [AW:0] ONE     = (AW+1)'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [AW-1:0]    wr_idx;
    logic [AW-1:0]    rd_idx;
    logic             wr_acc;
    logic             rd_acc;

    // The extra pointer bit makes wr_ptr - rd_ptr the exact occupancy, including DEPTH.
    assign wr_idx       = wr_ptr[AW-1:0];
    assign rd_idx       = rd_ptr[AW-1:0];
    assign count        = wr_ptr - rd_ptr;
    assign full         = (count == DEPTH_C);
    assign empty        = (count == '0);
    assign almost_full  = (count >= AF_C);
    assign almost_empty = (count <= AE_C);
    assign wr_acc       = write & ~full;
    assign rd_acc       = read & ~empty;

    always_ff @(posedge CLK) begin
        if (RST || flush) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + ONE;
            if (rd_acc) rd_ptr <= rd_ptr + ONE;
            if (write && full)  overflow  <= 1'b1;
            if (read  && empty) underflow <= 1'b1;
        end
    end

    // Storage is never cleared; only the pointers define what is valid.
    always_ff @(posedge CLK) begin
        if (!RST && !flush && wr_acc) mem[wr_idx] <= iData;
    end

`ifdef PARAM_SYNC_FIFO_FWFT_EN
    assign oData = empty ? '0 : mem[rd_idx];
`else
    always_ff @(posedge CLK) begin
        if (RST)                  oData <= '0;
        else if (!flush && rd_acc) oData <= mem[rd_idx];
    end
`endif

endmodule
